// File: rtl/mdu_pkg.sv
// Shared encodings, state enum and constants for the iterative multiply/divide unit.
package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int          MDU_ITERS = 32;
   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;

   function automatic logic is_div_op(input logic [1:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic is_signed_op(input logic [1:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_abs.sv
// Combinational two's-complement conditional negate; zero latency, no flow control.
module mdu_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] value,
   input  logic         negate,
   output logic [W-1:0] result
);

   assign result = negate ? -value : value;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU into HI/LO; 34-cycle start-to-done (divide by zero: 1), starts ignored while busy.
// Optional MDU_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are all zero.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int ITERS = MDU_ITERS
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int W  = WIDTH;
   localparam int CW = $clog2(ITERS + 1);
   localparam logic [CW-1:0] ITERS_C = CW'(ITERS);

   state_t           state, state_nxt;
   logic [1:0]       op_r;
   logic             sign_a, sign_b, dz;
   logic [2*W-1:0]   mcand, acc;
   logic [W-1:0]     mplier;
   logic [CW-1:0]    cnt;

   logic             accept, mul_last, div_last, cap_sgn, fix_sgn;
   logic [W-1:0]     rs_mag, rt_mag, quot_fix, rem_fix, rem_sub;
   logic [2*W-1:0]   prod_fix, div_acc;
   logic [W:0]       rem_sh;
   logic             rem_ge;

   assign busy   = (state == MUL) || (state == DIV) || (state == FIX);
   assign done   = (state == DONE);
   assign accept = start && !busy;

   assign cap_sgn = is_signed_op(op);
   assign fix_sgn = is_signed_op(op_r);

   mdu_abs #(.W(W)) u_abs_rs (.value(rs_val), .negate(cap_sgn && rs_val[W-1]), .result(rs_mag));
   mdu_abs #(.W(W)) u_abs_rt (.value(rt_val), .negate(cap_sgn && rt_val[W-1]), .result(rt_mag));

   mdu_abs #(.W(2*W)) u_fix_prod (.value(acc), .negate(fix_sgn && (sign_a ^ sign_b)), .result(prod_fix));
   mdu_abs #(.W(W)) u_fix_quot (.value(acc[W-1:0]), .negate(fix_sgn && (sign_a ^ sign_b)), .result(quot_fix));
   mdu_abs #(.W(W)) u_fix_rem (.value(acc[2*W-1:W]), .negate(fix_sgn && sign_a), .result(rem_fix));

   // Restoring step on {remainder, dividend/quotient}: shift left, subtract divisor if it fits.
   assign rem_sh  = acc[2*W-1:W-1];
   assign rem_ge  = rem_sh >= {1'b0, mplier};
   assign rem_sub = rem_sh[W-1:0] - mplier;
   assign div_acc = rem_ge ? {rem_sub, acc[W-2:0], 1'b1} : {acc[2*W-2:0], 1'b0};

`ifdef MDU_EARLY_OUT_EN
   assign mul_last = (cnt == ITERS_C) || ((cnt != '0) && (mplier == '0));
`else
   assign mul_last = (cnt == ITERS_C);
`endif
   assign div_last = (cnt == ITERS_C);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (start) state_nxt = is_div_op(op) ? DIV : MUL;
         MUL:  if (mul_last) state_nxt = FIX;
         DIV:  if (dz) state_nxt = DONE;
               else if (div_last) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: state_nxt = start ? (is_div_op(op) ? DIV : MUL) : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         op_r     <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         dz       <= 1'b0;
         mcand    <= '0;
         acc      <= '0;
         mplier   <= '0;
         cnt      <= '0;
         hi       <= '0;
         lo       <= '0;
         div_zero <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_r     <= op;
            sign_a   <= rs_val[W-1];
            sign_b   <= rt_val[W-1];
            dz       <= is_div_op(op) && (rt_val == '0);
            div_zero <= 1'b0;
            cnt      <= '0;
            mplier   <= rt_mag;
            acc      <= is_div_op(op) ? {{W{1'b0}}, rs_mag} : '0;
            // Divides keep the raw dividend here; it becomes HI on a zero divisor.
            mcand    <= {{W{1'b0}}, is_div_op(op) ? rs_val : rs_mag};
         end else begin
            case (state)
               MUL: if (!mul_last) begin
                  if (mplier[0]) acc <= acc + mcand;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  cnt    <= cnt + CW'(1);
               end
               DIV: if (dz) begin
                  hi       <= mcand[W-1:0];
                  lo       <= DIV0_QUOT;
                  div_zero <= 1'b1;
               end else if (!div_last) begin
                  acc <= div_acc;
                  cnt <= cnt + CW'(1);
               end
               FIX: if (is_div_op(op_r)) begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end else begin
                  hi <= prod_fix[2*W-1:W];
                  lo <= prod_fix[W-1:0];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector table plus hand sequences for busy/done timing, ignored starts, back-to-back and reset abort.
module tb_mult_div_unit;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val, rt_val;
   logic        busy, done, div_zero;
   logic [31:0] hi, lo;

   int n_checks = 0;
   int n_pass   = 0;

   mult_div_unit dut (
      .clk(clk), .rst(rst), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val),
      .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
      logic [31:0] m;
      int n;
`endif
      if (o[1]) return (b == 32'd0) ? 1 : 34;
`ifdef MDU_EARLY_OUT_EN
      m = (!o[0] && b[31]) ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
      return n + 2;
`else
      return 34;
`endif
   endfunction

   // Drives start for one edge (E0); returns 1 ns after E0.
   task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; rs_val = a; rt_val = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Counts edges after E0 until done is seen; -1 on timeout.
   task automatic wait_done(output int lat);
      lat = 0;
      while (!done && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!done) lat = -1;
   endtask

   initial begin
      int lat, ndone, first;

      vecs[0]  = '{2'b01, 32'd3,         32'd5,         32'd0,         32'd15,        1'b0};
      vecs[1]  = '{2'b00, 32'hFFFFFFFE,  32'd7,         32'hFFFFFFFF,  32'hFFFFFFF2,  1'b0};
      vecs[2]  = '{2'b01, 32'hFFFFFFFF,  32'hFFFFFFFF,  32'hFFFFFFFE,  32'h00000001,  1'b0};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFF,  32'hFFFFFFFD,  1'b0};
      vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
      vecs[5]  = '{2'b10, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0};
      vecs[6]  = '{2'b00, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFF,  32'hFFFFFFF2,  1'b0};
      vecs[7]  = '{2'b00, 32'h80000000,  32'h80000000,  32'h40000000,  32'h00000000,  1'b0};
      vecs[8]  = '{2'b10, 32'd7,         32'hFFFFFFFE,  32'd1,         32'hFFFFFFFD,  1'b0};
      vecs[9]  = '{2'b01, 32'd0,         32'd0,         32'd0,         32'd0,         1'b0};
      vecs[10] = '{2'b11, 32'd42,        32'd0,         32'd42,        32'hFFFFFFFF,  1'b1};
      vecs[11] = '{2'b10, 32'hFFFFFFF9,  32'd0,         32'hFFFFFFF9,  32'hFFFFFFFF,  1'b1};

      rst = 1'b1; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy", 64'(busy), 64'd0);
      chk("reset done", 64'(done), 64'd0);
      chk("reset hi", 64'(hi), 64'd0);
      chk("reset lo", 64'(lo), 64'd0);
      chk("reset div_zero", 64'(div_zero), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 12; i++) begin
         start_op(vecs[i].op, vecs[i].a, vecs[i].b);
         chk($sformatf("v%0d busy after E0", i), 64'(busy), 64'd1);
         wait_done(lat);
         chk($sformatf("v%0d latency", i), 64'(lat), 64'(exp_lat(vecs[i].op, vecs[i].b)));
         chk($sformatf("v%0d hi", i), 64'(hi), 64'(vecs[i].hi));
         chk($sformatf("v%0d lo", i), 64'(lo), 64'(vecs[i].lo));
         chk($sformatf("v%0d div_zero", i), 64'(div_zero), 64'(vecs[i].dz));
         chk($sformatf("v%0d busy in DONE", i), 64'(busy), 64'd0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d done one cycle", i), 64'(done), 64'd0);
      end

      // div_zero and HI/LO hold while idle, then div_zero clears on the next capture.
      repeat (3) @(posedge clk);
      #1;
      chk("dz hold div_zero", 64'(div_zero), 64'd1);
      chk("dz hold hi", 64'(hi), 64'hFFFFFFF9);
      chk("dz hold lo", 64'(lo), 64'hFFFFFFFF);
      start_op(2'b01, 32'd3, 32'd5);
      chk("dz cleared at capture", 64'(div_zero), 64'd0);
      wait_done(lat);
      chk("after dz lo", 64'(lo), 64'd15);

      // Second start at E0+10 of a MULT must be ignored.
      start_op(2'b00, 32'h00012345, 32'h40000000);
      ndone = 0; first = -1;
      for (int k = 1; k <= 45; k++) begin
         @(negedge clk);
         start = (k == 10); op = 2'b11; rs_val = 32'd1; rt_val = 32'd1;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (done) begin
            ndone++;
            if (first < 0) first = k;
         end
      end
      chk("ignored start done count", 64'(ndone), 64'd1);
      chk("ignored start latency", 64'(first), 64'(exp_lat(2'b00, 32'h40000000)));
      chk("ignored start hi", 64'(hi), 64'h000048D1);
      chk("ignored start lo", 64'(lo), 64'h40000000);

      // Start during the DONE cycle is accepted.
      start_op(2'b01, 32'd6, 32'd9);
      wait_done(lat);
      chk("b2b first lo", 64'(lo), 64'd54);
      @(negedge clk);
      start = 1'b1; op = 2'b01; rs_val = 32'hFFFFFFFF; rt_val = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("b2b busy next cycle", 64'(busy), 64'd1);
      chk("b2b done dropped", 64'(done), 64'd0);
      wait_done(lat);
      chk("b2b second latency", 64'(lat), 64'(exp_lat(2'b01, 32'd3)));
      chk("b2b second hi", 64'(hi), 64'd2);
      chk("b2b second lo", 64'(lo), 64'hFFFFFFFD);

      // Reset sampled at E0+12 of a divide aborts it.
      start_op(2'b11, 32'd1000, 32'd3);
      repeat (11) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("abort busy", 64'(busy), 64'd0);
      chk("abort done", 64'(done), 64'd0);
      chk("abort hi", 64'(hi), 64'd0);
      chk("abort lo", 64'(lo), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int k = 0; k < 22; k++) begin
         @(posedge clk);
         #1;
         if (done || busy) ndone++;
      end
      chk("abort no later activity", 64'(ndone), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit in the execute stage; sits directly downstream of the register file.
- Consumes the two source-register operand values for MULT/MULTU/DIV/DIVU instructions.
- Produces a 64-bit result into internal HI/LO registers, which feed the writeback mux (MFHI/MFLO).
- Uses a start/busy/done handshake so the pipeline controller can stall while it runs.

Parameters:
- WIDTH, 32, operand and HI/LO width; only 32 is supported and verified.
- ITERS, 32, iteration count for the full-latency path; must equal WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only when busy=0.
- op  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; HI/LO are valid from this cycle.
- hi  out  WIDTH  multiply upper product word / divide remainder.
- lo  out  WIDTH  multiply lower product word / divide quotient.
- div_zero  out  1  last divide had a zero divisor.

Behaviour:
- Reset: state IDLE; busy=0, done=0, hi=0, lo=0, div_zero=0; the iteration counter is cleared.
- Reset mid-operation aborts the operation; the same reset values apply and no done pulse is produced.
- States:
  - IDLE: waits for start.
  - MUL: shift-add, one multiplier bit per cycle.
  - DIV: restoring divide, one quotient bit per cycle.
  - FIX: sign correction, one cycle.
  - DONE: one cycle; done=1; returns to IDLE.
- Operand capture, on the edge E0 where start=1 and busy=0:
  - latch op;
  - latch |rs_val| and |rt_val| for signed ops, raw values for unsigned ops;
  - latch the operand signs;
  - clear div_zero.
- Busy timing: busy=1 from after E0 through FIX; busy=0 in the DONE cycle.
- Start while busy=1 is ignored. Start during the DONE cycle is accepted, giving back-to-back operations.
- Latency, full path: MUL/DIV for 32 cycles, FIX at E0+33, DONE state after E0+34.
  - hi/lo update on the edge entering DONE.
  - done is high for exactly one cycle.
- Multiply:
  - 64-bit product of the magnitudes.
  - Signed op: negate the 64-bit product if the operand signs differ.
  - hi = product[63:32], lo = product[31:0].
- Divide:
  - Quotient and remainder of the magnitudes.
  - Signed op: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0 (natural wrap, no trap).
- Divide by zero:
  - Detected at E0; skips DIV and FIX and goes to DONE after E0+1.
  - lo=0xFFFFFFFF, hi=rs_val (raw), div_zero=1.
  - div_zero holds until the next accepted start or reset.
- hi/lo hold their values between operations; they change only in DONE or on reset.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined:
  - MUL leaves after the iteration that makes the remaining multiplier shift register zero, with a minimum of 1 iteration.
  - Multiply latency = n+2 cycles, where n = max(1, position of highest set bit of the multiplier magnitude + 1).
  - DIV latency is unchanged.
- Undefined: MUL always runs 32 iterations.
- Results are identical in both builds.

Decomposition:
- Package mdu_pkg:
  - op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - state enum (IDLE, MUL, DIV, FIX, DONE);
  - MDU_ITERS=32 and the divide-by-zero quotient constant 0xFFFFFFFF.
- One sub-module, mdu_abs: combinational two's-complement conditional negate, parameterised width.
  - Used at capture (32-bit) and in FIX (64-bit product, 32-bit quotient and remainder).

Test Plan:
1. MULTU 3 x 5, start at E0 -> busy after E0; done pulse after E0+34 (or E0+5 with MDU_EARLY_OUT_EN); hi=0, lo=15.
2. MULT 0xFFFFFFFE x 7 (-2 x 7) -> hi=0xFFFFFFFF, lo=0xFFFFFFF2. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
3. DIV results at E0+34:
   - -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - DIVU 100 / 7 -> lo=14, hi=2.
   - 0x80000000 / 0xFFFFFFFF (DIV) -> lo=0x80000000, hi=0.
4. DIVU 42 / 0 -> done after E0+1; lo=0xFFFFFFFF, hi=42, div_zero=1. Then a MULTU start -> div_zero=0 after capture.
5. Second start pulsed at E0+10 during a MULT -> ignored, single done. Start asserted in the DONE cycle -> new operation accepted, busy high next cycle.
6. rst=1 at E0+12 mid-DIV -> next cycle busy=0, done=0, hi=lo=0. No done pulse follows for the remaining 22 cycles.
